sa_feeder: RTL
==============

Name: sa_feeder

Overview:
- Operand staging stage directly upstream of the N x N systolic-array core.
- Accepts an A/B operand set as N handshaked beats. Each beat carries one column of A, the matching row of B, and, on beat 0 only, the N-entry C preload.
- Replays the stored beats diagonally skewed: lane i is delayed i cycles, forming the systolic wavefront.
- Pulses the core's input-valid on the final skewed element, then holds off the next operand set until the core reports completion.

Parameters:
- DIN_WIDTH, 8, width of one A/B element; C elements are 2*DIN_WIDTH.
- N, 4, array dimension (lanes, beats per operand set); N >= 2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- ld_valid  input  1  load beat valid.
- ld_ready  output  1  feeder can accept a load beat.
- ld_a  input  N x DIN_WIDTH  column k of A, element i on lane i.
- ld_b  input  N x DIN_WIDTH  row k of B, element j on lane j.
- ld_c  input  N x 2*DIN_WIDTH  C preload; sampled only on beat 0.
- sa_a  output  N x DIN_WIDTH  skewed A lanes to the core.
- sa_b  output  N x DIN_WIDTH  skewed B lanes to the core.
- sa_c  output  N x 2*DIN_WIDTH  C preload to the core, held stable.
- sa_in_valid  output  1  one-cycle pulse on the last skewed element.
- sa_done  input  1  completion pulse from the core's output-valid.
- busy  output  1  high in every state except LOAD.

Behaviour:
- Storage: A and B buffers of N beats x N lanes, plus a C register of N x 2*DIN_WIDTH. Single buffered.
- FSM states: LOAD, STREAM, WAIT_DONE.
- LOAD:
  - ld_ready = 1.
  - Each cycle with ld_valid & ld_ready writes buffer[k] and increments beat counter k (0..N-1).
  - Beat 0 also captures ld_c.
  - Accepting beat N-1 moves to STREAM next cycle with t = 0.
- STREAM:
  - Runs exactly 2N-1 cycles, t = 0..2N-2.
  - Lane i outputs sa_a[i] = A_buf[t-i][i] and sa_b[i] = B_buf[t-i][i] when 0 <= t-i < N, else 0.
  - sa_in_valid = 1 only at t = 2N-2; then moves to WAIT_DONE.
- WAIT_DONE:
  - sa_a and sa_b are 0.
  - On sa_done moves to LOAD with k = 0.
- sa_done outside WAIT_DONE is ignored; it is not latched.
- sa_c holds the captured value from STREAM entry until the next beat-0 capture.
- Latency:
  - First nonzero lane-0 output appears in the cycle after the beat N-1 handshake.
  - Minimum turnaround from that handshake to the next ld_ready is 2N-1 STREAM cycles plus WAIT_DONE (at least 1 cycle).
- Outputs are registered, driven from state/counter decode registered one stage; there is no combinational path from ld_* to sa_*.
- Counters: k is $clog2(N) bits, t is $clog2(2N-1) bits. No wrap beyond terminal values; transitions are on equality.
- ld_valid low mid-load: hold k, no data change. Gaps between beats are permitted.
- ld_* values when ld_ready = 0 are ignored.
- Reset, asserted at any time, takes effect immediately:
  - state = LOAD, k = t = 0.
  - ld_ready = 1 once reset deasserts; busy = 0.
  - sa_a = sa_b = sa_c = 0; sa_in_valid = 0.
  - Buffer contents are not reset (don't-care).
- Reset mid-STREAM: any partially streamed set is abandoned. sa_in_valid must not pulse for it.

Decomposition:
- Shared package sa_pkg holds:
  - typedefs elem_t = logic[DIN_WIDTH-1:0] and acc_t = logic[2*DIN_WIDTH-1:0];
  - enum feeder_state_e {LOAD, STREAM, WAIT_DONE};
  - constant function stream_len(N) = 2N-1.
- One sub-module, sa_skew_lane: per-lane index select and zero-gating given t and a lane index parameter. It is instantiated 2N times (A and B lanes).

Test Plan:
- Basic skew, N=4, A column k = {k*4+0..3}, B row k = {16+k*4+0..3}, 4 back-to-back beats -> 7 STREAM cycles.
  - t=0: sa_a = {0,0,0,0}→lane0 = 0x00.
  - t=3: lanes 0..3 = A[3][0], A[2][1], A[1][2], A[0][3] = 12, 9, 6, 3.
  - t=6: lane3 = A[3][3] = 15, other lanes 0.
  - sa_in_valid high only at t=6.
- C preload: beat 0 ld_c = {0x1111, 0x2222, 0x3333, 0x4444}, beat 1 ld_c = 0xFFFF -> sa_c = {0x1111..0x4444} throughout STREAM.
- Load gaps: ld_valid pattern 1,0,0,1,1,0,1 -> exactly 4 beats accepted; STREAM starts the cycle after the 7th cycle.
- Completion gating:
  - During WAIT_DONE, hold sa_done low 10 cycles -> ld_ready stays 0 and no stores occur.
  - Pulse sa_done -> ld_ready = 1 next cycle.
  - A spurious sa_done during STREAM has no effect.
- Async reset at t=3: outputs go to 0 without a clock edge, no sa_in_valid pulse follows, ld_ready = 1 after release, k restarts at 0.
- Back-to-back sets: two operand sets with distinct data, sa_done one cycle after each sa_in_valid -> second stream is correct, with no stale lanes from the first.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic-array operand feeder.
package sa_pkg;

    localparam int DEF_DIN_WIDTH = 8;

    typedef logic [DEF_DIN_WIDTH-1:0]   elem_t;
    typedef logic [2*DEF_DIN_WIDTH-1:0] acc_t;

    typedef enum logic [1:0] {
        LOAD      = 2'd0,
        STREAM    = 2'd1,
        WAIT_DONE = 2'd2
    } feeder_state_e;

    // Number of cycles needed to push an N-deep skewed wavefront through N lanes.
    function automatic int unsigned stream_len(input int unsigned n);
        return (32'd2 * n) - 32'd1;
    endfunction

endpackage

// File: rtl/sa_skew_lane.sv
// One skewed lane: picks beat (t - LANE) of this lane from the operand buffer,
// or drives zero when that beat index falls outside the stored set.
module sa_skew_lane
    import sa_pkg::*;
#(
    parameter int DIN_WIDTH = 8,
    parameter int N         = 4,
    parameter int LANE      = 0,
    parameter int TW        = 3
) (
    input  logic [TW-1:0]        t,
    input  logic                 en,
    input  logic [DIN_WIDTH-1:0] data_buf [N][N],
    output logic [DIN_WIDTH-1:0] elem
);

    localparam int            KW      = $clog2(N);
    localparam logic [TW-1:0] LANE_T  = TW'(LANE);
    localparam logic [TW-1:0] DEPTH_T = TW'(N);

    // When t < LANE the subtraction wraps to a value >= N because the t
    // counter is wide enough for 2N-1, so one compare covers both bounds.
    logic [TW-1:0] idx_s;
    logic [KW-1:0] beat_s;

    assign idx_s  = t - LANE_T;
    assign beat_s = idx_s[KW-1:0];

    // Select the delayed element for this lane, zero outside the wavefront.
    always_comb begin
        elem = {DIN_WIDTH{1'b0}};
        if (en && (idx_s < DEPTH_T)) begin
            elem = data_buf[beat_s][LANE];
        end else begin
            elem = {DIN_WIDTH{1'b0}};
        end
    end

endmodule

// File: rtl/sa_feeder.sv
// Operand staging for the N x N systolic core: collects N load beats,
// replays them as a diagonal wavefront, then waits for the core to finish.
module sa_feeder
    import sa_pkg::*;
#(
    parameter int DIN_WIDTH = 8,
    parameter int N         = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ld_valid,
    output logic                              ld_ready,
    input  logic [N-1:0][DIN_WIDTH-1:0]       ld_a,
    input  logic [N-1:0][DIN_WIDTH-1:0]       ld_b,
    input  logic [N-1:0][2*DIN_WIDTH-1:0]     ld_c,
    output logic [N-1:0][DIN_WIDTH-1:0]       sa_a,
    output logic [N-1:0][DIN_WIDTH-1:0]       sa_b,
    output logic [N-1:0][2*DIN_WIDTH-1:0]     sa_c,
    output logic                              sa_in_valid,
    input  logic                              sa_done,
    output logic                              busy
);

    localparam int            SLEN   = int'(stream_len(N));
    localparam int            KW     = $clog2(N);
    localparam int            TW     = $clog2(SLEN);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);
    localparam logic [TW-1:0] T_LAST = TW'(SLEN - 1);

    feeder_state_e state_r;
    feeder_state_e state_next_s;
    logic [KW-1:0] k_r;
    logic [KW-1:0] k_next_s;
    logic [TW-1:0] t_r;
    logic [TW-1:0] t_next_s;
    logic          accept_s;
    logic          stream_next_s;

    logic [DIN_WIDTH-1:0] a_buf_r [N][N];
    logic [DIN_WIDTH-1:0] b_buf_r [N][N];

    logic [N-1:0][DIN_WIDTH-1:0]   sa_a_next_s;
    logic [N-1:0][DIN_WIDTH-1:0]   sa_b_next_s;
    logic [N-1:0][DIN_WIDTH-1:0]   sa_a_r;
    logic [N-1:0][DIN_WIDTH-1:0]   sa_b_r;
    logic [N-1:0][2*DIN_WIDTH-1:0] sa_c_r;
    logic                          sa_in_valid_r;
    logic                          ld_ready_r;
    logic                          busy_r;

    // ld_ready_r mirrors "state is LOAD", so it doubles as the accept gate.
    assign accept_s      = ld_valid & ld_ready_r;
    assign stream_next_s = (state_next_s == STREAM);

    // Next-state and counter decode for the load / stream / wait sequence.
    always_comb begin
        state_next_s = state_r;
        k_next_s     = k_r;
        t_next_s     = t_r;
        case (state_r)
            LOAD: begin
                if (accept_s) begin
                    if (k_r == K_LAST) begin
                        state_next_s = STREAM;
                        t_next_s     = {TW{1'b0}};
                    end else begin
                        k_next_s = k_r + KW'(1'b1);
                    end
                end else begin
                    k_next_s = k_r;
                end
            end
            STREAM: begin
                if (t_r == T_LAST) begin
                    state_next_s = WAIT_DONE;
                    t_next_s     = {TW{1'b0}};
                end else begin
                    t_next_s = t_r + TW'(1'b1);
                end
            end
            WAIT_DONE: begin
                if (sa_done) begin
                    state_next_s = LOAD;
                    k_next_s     = {KW{1'b0}};
                end else begin
                    state_next_s = WAIT_DONE;
                end
            end
            default: begin
                state_next_s = LOAD;
                k_next_s     = {KW{1'b0}};
                t_next_s     = {TW{1'b0}};
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= LOAD;
            k_r     <= {KW{1'b0}};
            t_r     <= {TW{1'b0}};
        end else begin
            state_r <= state_next_s;
            k_r     <= k_next_s;
            t_r     <= t_next_s;
        end
    end

    // Operand buffers; contents are only meaningful after a full load.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            for (int i = 0; i < N; i++) begin
                a_buf_r[k_r][i] <= ld_a[i];
                b_buf_r[k_r][i] <= ld_b[i];
            end
        end
    end

    // Lane selectors are fed the next-cycle t so the lane outputs can be
    // registered and still line up with the STREAM cycle they belong to.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        sa_skew_lane #(
            .DIN_WIDTH (DIN_WIDTH),
            .N         (N),
            .LANE      (gi),
            .TW        (TW)
        ) u_skew_a (
            .t        (t_next_s),
            .en       (stream_next_s),
            .data_buf (a_buf_r),
            .elem     (sa_a_next_s[gi])
        );

        sa_skew_lane #(
            .DIN_WIDTH (DIN_WIDTH),
            .N         (N),
            .LANE      (gi),
            .TW        (TW)
        ) u_skew_b (
            .t        (t_next_s),
            .en       (stream_next_s),
            .data_buf (b_buf_r),
            .elem     (sa_b_next_s[gi])
        );
    end

    // Registered core-facing outputs and handshake/status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa_a_r        <= '{default: {DIN_WIDTH{1'b0}}};
            sa_b_r        <= '{default: {DIN_WIDTH{1'b0}}};
            sa_in_valid_r <= 1'b0;
            ld_ready_r    <= 1'b1;
            busy_r        <= 1'b0;
        end else begin
            sa_a_r        <= sa_a_next_s;
            sa_b_r        <= sa_b_next_s;
            sa_in_valid_r <= stream_next_s && (t_next_s == T_LAST);
            ld_ready_r    <= (state_next_s == LOAD);
            busy_r        <= (state_next_s != LOAD);
        end
    end

    // C preload is captured on beat 0 and held for the core until the next beat 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa_c_r <= '{default: {(2*DIN_WIDTH){1'b0}}};
        end else if (accept_s && (k_r == {KW{1'b0}})) begin
            sa_c_r <= ld_c;
        end else begin
            sa_c_r <= sa_c_r;
        end
    end

    assign sa_a        = sa_a_r;
    assign sa_b        = sa_b_r;
    assign sa_c        = sa_c_r;
    assign sa_in_valid = sa_in_valid_r;
    assign ld_ready    = ld_ready_r;
    assign busy        = busy_r;

endmodule
